// File: rtl/imem_if.sv
// Instruction-memory interface feeding the fetch stage.
// Turns the fetch next-PC into requests on a variable-latency memory port.
// Each returned word lands in a one-entry tagged buffer.
// Memory errors and misaligned PCs park the block in a sticky fault.

module imem_if (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_req_i,
    input  logic        halt_i,
    output logic [31:0] inst_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        fault_o,
    output logic [31:0] fault_addr_o
);

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        REQ,
        WAIT,
        FAULT
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        buf_valid;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;
    logic [31:0] req_addr;
    logic [31:0] fault_addr;

    logic        hit;
    logic        capture_req;
    logic        fill;
    logic        take_fault;
    logic [31:0] fault_addr_nxt;

    // Hit compare is purely combinational so the fetch stage sees stall in the same cycle
    always_comb begin
        hit = buf_valid && (buf_addr == pc_req_i);
    end

    // Fetch-facing outputs: buffered word, stall gating, and fault status
    always_comb begin
        inst_o       = buf_data;
        stall_o      = halt_i | ~hit | (state == FAULT);
        fault_o      = (state == FAULT);
        fault_addr_o = fault_addr;
    end

    // Next-state and memory request generation; a miss in IDLE issues in the same cycle
    always_comb begin
        state_nxt      = state;
        mem_req_o      = 1'b0;
        mem_addr_o     = 32'h0;
        capture_req    = 1'b0;
        fill           = 1'b0;
        take_fault     = 1'b0;
        fault_addr_nxt = fault_addr;
        case (state)
            BOOT: begin
                state_nxt = IDLE;
            end
            IDLE: begin
                if (!hit && !halt_i) begin
                    if (pc_req_i[1:0] != 2'b00) begin
                        take_fault     = 1'b1;
                        fault_addr_nxt = pc_req_i;
                        state_nxt      = FAULT;
                    end else begin
                        mem_req_o   = 1'b1;
                        mem_addr_o  = pc_req_i;
                        capture_req = 1'b1;
                        state_nxt   = mem_gnt_i ? WAIT : REQ;
                    end
                end
            end
            REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = req_addr;
                if (mem_gnt_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    if (mem_err_i) begin
                        take_fault     = 1'b1;
                        fault_addr_nxt = req_addr;
                        state_nxt      = FAULT;
                    end else begin
                        fill      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // State, pending address, buffer and fault registers; reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            buf_valid  <= 1'b0;
            buf_addr   <= 32'h0;
            buf_data   <= 32'h0;
            req_addr   <= 32'h0;
            fault_addr <= 32'h0;
        end else begin
            state <= state_nxt;
            if (capture_req) begin
                req_addr <= pc_req_i;
            end
            if (fill) begin
                buf_valid <= 1'b1;
                buf_addr  <= req_addr;
                buf_data  <= mem_rdata_i;
            end
            if (take_fault) begin
                fault_addr <= fault_addr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_imem_if.sv
// Directed bench for imem_if with scoreboard queues for granted request
// addresses and for instruction words expected on a later hit.

module tb_imem_if;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_req_i;
    logic        halt_i;
    logic [31:0] inst_o;
    logic        stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        fault_o;
    logic [31:0] fault_addr_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_req[$];
    logic [31:0] exp_inst[$];

    imem_if dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_req_i     (pc_req_i),
        .halt_i       (halt_i),
        .inst_o       (inst_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i),
        .fault_o      (fault_o),
        .fault_addr_o (fault_addr_o)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic reportEmpty(input string tag);
        checks++;
        errors++;
        $error("[TB] FAIL %s: observed event with empty scoreboard, expected none", tag);
    endtask

    // Drive one cycle of inputs, let combinational outputs settle, score any grant handshake
    task automatic applyStimulus(input logic [31:0] pc, input logic halt, input logic gnt,
                                 input logic rvalid, input logic [31:0] rdata, input logic err);
        pc_req_i     = pc;
        halt_i       = halt;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rvalid;
        mem_rdata_i  = rdata;
        mem_err_i    = err;
        if (rvalid && !err) exp_inst.push_back(rdata);
        #1;
        if (mem_req_o && gnt) begin
            if (exp_req.size() == 0) reportEmpty("grant_addr");
            else checkOutput("grant_addr", mem_addr_o, exp_req.pop_front());
        end
    endtask

    task automatic checkInst(input string tag);
        if (exp_inst.size() == 0) reportEmpty(tag);
        else checkOutput(tag, inst_o, exp_inst.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Linear directed sequence
    initial begin
        rst_n = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_inst", inst_o, 32'h0);
        checkOutput("rst_stall", {31'h0, stall_o}, 32'h1);
        checkOutput("rst_req", {31'h0, mem_req_o}, 32'h0);
        checkOutput("rst_addr", mem_addr_o, 32'h0);
        checkOutput("rst_fault", {31'h0, fault_o}, 32'h0);
        checkOutput("rst_faddr", fault_addr_o, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Best-case miss: BOOT cycle, then request at 0x0 granted immediately
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("boot_req", {31'h0, mem_req_o}, 32'h0);
        tick();
        exp_req.push_back(32'h0);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("first_req", {31'h0, mem_req_o}, 32'h1);
        checkOutput("first_stall", {31'h0, stall_o}, 32'h1);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
        checkOutput("wait_req", {31'h0, mem_req_o}, 32'h0);
        checkOutput("wait_stall", {31'h0, stall_o}, 32'h1);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("hit0_stall", {31'h0, stall_o}, 32'h0);
        checkOutput("hit0_req", {31'h0, mem_req_o}, 32'h0);
        checkInst("hit0_inst");
        tick();

        // Grant held off three cycles with a redirect to 0x8 meanwhile
        exp_req.push_back(32'h4);
        applyStimulus(32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("req4_addr", mem_addr_o, 32'h4);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("req4_hold", mem_addr_o, 32'h4);
            checkOutput("req4_stall", {31'h0, stall_o}, 32'h1);
            tick();
        end
        applyStimulus(32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("req4_gnt_req", {31'h0, mem_req_o}, 32'h1);
        tick();
        applyStimulus(32'h8, 1'b0, 1'b0, 1'b1, 32'hAAAA_0004, 1'b0);
        checkOutput("rsp4_stall", {31'h0, stall_o}, 32'h1);
        tick();
        applyStimulus(32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("hit4_stall", {31'h0, stall_o}, 32'h0);
        checkInst("hit4_inst");
        tick();
        exp_req.push_back(32'h8);
        applyStimulus(32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("req8_addr", mem_addr_o, 32'h8);
        checkOutput("req8_stall", {31'h0, stall_o}, 32'h1);
        tick();
        applyStimulus(32'h8, 1'b0, 1'b0, 1'b1, 32'hBBBB_0008, 1'b0);
        checkOutput("rsp8_stall", {31'h0, stall_o}, 32'h1);
        tick();
        applyStimulus(32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("hit8_stall", {31'h0, stall_o}, 32'h0);
        checkInst("hit8_inst");
        tick();

        // Fill 0x10, then halt gates stall on a hit and blocks issue on a miss
        exp_req.push_back(32'h10);
        applyStimulus(32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(32'h10, 1'b0, 1'b0, 1'b1, 32'hCCCC_0010, 1'b0);
        tick();
        applyStimulus(32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("halt_hit_stall", {31'h0, stall_o}, 32'h1);
        checkOutput("halt_hit_req", {31'h0, mem_req_o}, 32'h0);
        tick();
        applyStimulus(32'h14, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("halt_miss_req", {31'h0, mem_req_o}, 32'h0);
        tick();
        applyStimulus(32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("unhalt_stall", {31'h0, stall_o}, 32'h0);
        checkInst("unhalt_inst");
        tick();

        // Error response at 0x20 parks the block in a sticky fault
        exp_req.push_back(32'h20);
        applyStimulus(32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(32'h20, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        checkOutput("err_fault", {31'h0, fault_o}, 32'h1);
        checkOutput("err_faddr", fault_addr_o, 32'h20);
        checkOutput("err_inst_kept", inst_o, 32'hCCCC_0010);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'h20, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
            exp_inst.delete();
            checkOutput("fault_stall", {31'h0, stall_o}, 32'h1);
            checkOutput("fault_req", {31'h0, mem_req_o}, 32'h0);
            checkOutput("fault_sticky", {31'h0, fault_o}, 32'h1);
            tick();
        end
        rst_n = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst2_fault", {31'h0, fault_o}, 32'h0);
        checkOutput("rst2_faddr", fault_addr_o, 32'h0);
        checkOutput("rst2_inst", inst_o, 32'h0);
        tick();
        rst_n = 1'b1;

        // Misaligned PC on a miss: no request, immediate fault
        applyStimulus(32'h22, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(32'h22, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("mis_req", {31'h0, mem_req_o}, 32'h0);
        checkOutput("mis_stall", {31'h0, stall_o}, 32'h1);
        tick();
        checkOutput("mis_fault", {31'h0, fault_o}, 32'h1);
        checkOutput("mis_faddr", fault_addr_o, 32'h22);

        // Reset during WAIT with a late response must not touch the buffer
        rst_n = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        applyStimulus(32'h30, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        exp_req.push_back(32'h30);
        applyStimulus(32'h30, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b0;
        applyStimulus(32'h30, 1'b0, 1'b0, 1'b1, 32'hDEAD_0030, 1'b0);
        exp_inst.delete();
        checkOutput("rstw_inst", inst_o, 32'h0);
        checkOutput("rstw_stall", {31'h0, stall_o}, 32'h1);
        tick();
        rst_n = 1'b1;
        applyStimulus(32'h30, 1'b0, 1'b0, 1'b1, 32'hDEAD_0030, 1'b0);
        exp_inst.delete();
        tick();
        applyStimulus(32'h30, 1'b0, 1'b0, 1'b1, 32'hDEAD_0030, 1'b0);
        exp_inst.delete();
        checkOutput("late_inst", inst_o, 32'h0);
        checkOutput("late_stall", {31'h0, stall_o}, 32'h1);
        checkOutput("late_reissue", mem_addr_o, 32'h30);
        tick();

        checkOutput("req_queue_empty", exp_req.size(), 32'h0);
        checkOutput("inst_queue_empty", exp_inst.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_if.md
# imem_if

Instruction-memory interface that sits directly upstream of the fetch stage. It turns the fetch stage's next-PC address into a request on a variable-latency instruction memory port. Each returned word is held in a one-entry tagged buffer. The block supplies the fetch stage with the instruction word and with the hold signal that gates the fetch stage's PC/IR update. Memory errors and misaligned PCs stop the core with a sticky fault.

## Interface
- No parameters; address and data are fixed at 32 bits.
- Reset is asynchronous and active-low. There is one clock.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pc_req_i  in  32  address the fetch stage will load next (fetch next-PC input)
- halt_i  in  1  external halt request (debug/system halt)
- inst_o  out  32  instruction word for pc_req_i; drives the fetch instruction input
- stall_o  out  1  drives the fetch stage's halt input; 1 = fetch must not update
- mem_req_o  out  1  memory request valid
- mem_addr_o  out  32  memory request word address
- mem_gnt_i  in  1  memory accepts the request this cycle
- mem_rvalid_i  in  1  read response valid
- mem_rdata_i  in  32  read response data
- mem_err_i  in  1  response carries an error; qualified by mem_rvalid_i
- fault_o  out  1  sticky fault flag
- fault_addr_o  out  32  address that caused the fault

## Operation
- State: buf_valid, buf_addr[31:0], buf_data[31:0], req_addr[31:0], fault regs, FSM {BOOT, IDLE, REQ, WAIT, FAULT}.
- Hit = buf_valid && buf_addr == pc_req_i.
- inst_o = buf_data at all times.
- stall_o = halt_i | ~hit | (state == FAULT).
- BOOT: entered on reset; mem_req_o=0; moves to IDLE after one cycle.
- IDLE, hit: no request is issued.
- IDLE, miss, halt_i=0, pc_req_i[1:0]!=0:
  - no request is issued;
  - fault_addr <= pc_req_i;
  - go to FAULT.
- IDLE, miss, halt_i=0, aligned:
  - mem_req_o=1 and mem_addr_o=pc_req_i, combinationally in the same cycle;
  - req_addr <= pc_req_i;
  - go to WAIT if mem_gnt_i=1, otherwise go to REQ.
- IDLE, miss, halt_i=1: no new request is issued.
- REQ: mem_req_o=1 and mem_addr_o=req_addr, held stable until mem_gnt_i=1, then go to WAIT. Changes on pc_req_i do not alter the pending address.
- WAIT: mem_req_o=0. On mem_rvalid_i:
  - mem_err_i=0: buf_addr <= req_addr, buf_data <= mem_rdata_i, buf_valid <= 1, go to IDLE.
  - mem_err_i=1: buffer is unchanged, fault_addr <= req_addr, go to FAULT.
- Redirect (pc_req_i changes while in REQ/WAIT): the in-flight access completes and fills the buffer with its own address. IDLE then sees the miss and issues the new request. No response is dropped.
- FAULT: fault_o=1, mem_req_o=0, stall_o=1. Only reset exits this state.
- At most one outstanding request. mem_gnt_i is ignored outside IDLE/REQ request cycles. mem_rvalid_i is ignored outside WAIT.
- halt_i only gates stall_o and the issue of new requests. An outstanding access completes normally while halted.

## Timing
- Reset values:
  - state=BOOT, buf_valid=0, buf_addr=0, buf_data=0, req_addr=0;
  - inst_o=0, stall_o=1, mem_req_o=0, mem_addr_o=0;
  - fault_o=0, fault_addr_o=0.
- Reset mid-access: all state clears. A late mem_rvalid_i after reset is ignored, because the FSM is not in WAIT.
- The memory may assert mem_rvalid_i no earlier than the cycle after mem_gnt_i.
- Best-case miss latency:
  - miss seen and granted in cycle N;
  - rvalid in cycle N+1;
  - hit and stall_o=0 in cycle N+2.
- Each added grant or response wait cycle adds one cycle of latency.
- The first request after reset is issued in the second cycle after rst_n deasserts (one BOOT cycle).
- stall_o and the hit compare are combinational from pc_req_i and halt_i. The fetch stage samples them at the same clock edge.
- Sustained throughput with 1-cycle memory: one instruction per 3 cycles.

## Test plan
- Reset, pc_req_i=0x0, memory grants immediately, rvalid+data 0x00000013 one cycle later -> request to 0x0 in the 2nd post-reset cycle; inst_o=0x13 and stall_o=0 two cycles after grant.
- pc_req_i=0x4, mem_gnt_i held low 3 cycles, pc_req_i changed to 0x8 meanwhile -> mem_addr_o stays 0x4 until grant; buffer fills 0x4; then a new request to 0x8 is issued; stall_o=1 until 0x8 data returns.
- Buffer holds 0x10 and pc_req_i=0x10 while halt_i=1 -> stall_o=1, no mem_req_o; halt_i drops -> stall_o=0 the same cycle.
- Response to 0x20 with mem_err_i=1 -> fault_o=1, fault_addr_o=0x20 next cycle; stall_o stays 1 and mem_req_o stays 0 for 10+ cycles until rst_n pulses.
- pc_req_i=0x22 on a miss -> no request; fault_o=1, fault_addr_o=0x22.
- rst_n asserted in WAIT, rvalid arrives during/after reset -> buf_valid=0, inst_o=0, no buffer write.
